linear_sorter_ctrl: RTL

Frame sequencer for the linear sorter array, a chain of `smart8bitcell` instances. It accepts a frame of up to `DEPTH` bytes over a valid/ready stream and broadcasts each byte to the array. It then reads the sorted contents back out of the parallel cell bus as a valid/ready stream, and clears the array between frames. It sits between the upstream byte source and the downstream consumer, and owns all array control.

---
 rtl/sorter_pkg.sv | 14 +
 rtl/sorter_read_mux.sv | 22 ++
 rtl/linear_sorter_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sorter_pkg.sv
// Shared types and constants for the linear sorter controller.
package sorter_pkg;

    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] SENTINEL = 8'hFF;

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        FLUSH,
        DRAIN
    } sorter_state_e;

endpackage

// File: rtl/sorter_read_mux.sv
// DEPTH-way byte selector over the concatenated cell bus; cell 0 sits in bits [7:0].
module sorter_read_mux
    import sorter_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IdxW  = 4
) (
    input  logic [DATA_W*DEPTH-1:0] cell_data,
    input  logic [IdxW-1:0]         idx,
    output logic [DATA_W-1:0]       data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == IdxW'(i)) begin
                data = cell_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/linear_sorter_ctrl.sv
// Frame sequencer for the smart8bitcell sorter chain: load, flush, drain, clear.
// Define LINEAR_SORTER_CTRL_DESCENDING_EN to drain largest-first.
module linear_sorter_ctrl
    import sorter_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    arr_clear,
    output logic [DATA_W-1:0]       arr_new_data,
    input  logic [DATA_W*DEPTH-1:0] arr_cell_data,
    output logic                    frame_trunc,
    output logic                    busy
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [CntW-1:0] OneC   = CntW'(1);

    sorter_state_e     state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [CntW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] new_data_q, new_data_d;
    logic              trunc_q, trunc_d;

    logic [CntW-1:0]   idx_first;
    logic [CntW-1:0]   idx_final;
    logic [CntW-1:0]   idx_next;
    logic              accept;

`ifdef LINEAR_SORTER_CTRL_DESCENDING_EN
    assign idx_first = count_q - OneC;
    assign idx_final = '0;
    assign idx_next  = idx_q - OneC;
`else
    assign idx_first = '0;
    assign idx_final = count_q - OneC;
    assign idx_next  = idx_q + OneC;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        new_data_d = SENTINEL;
        trunc_d    = 1'b0;
        in_ready   = 1'b0;
        accept     = 1'b0;

        unique case (state_q)
            CLEAR: begin
                count_d = '0;
                idx_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                in_ready = (count_q < DepthC);
                accept   = in_valid && in_ready;
                if (accept) begin
                    new_data_d = in_data;
                    count_d    = count_q + OneC;
                    if (in_last || (count_d == DepthC)) begin
                        state_d = FLUSH;
                        // Full without in_last: the rest of the stream starts the next frame.
                        trunc_d = !in_last;
                    end
                end
            end
            FLUSH: begin
                idx_d   = idx_first;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_q == idx_final) begin
                        state_d = CLEAR;
                    end else begin
                        idx_d = idx_next;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CLEAR;
            count_q    <= '0;
            idx_q      <= '0;
            new_data_q <= SENTINEL;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            new_data_q <= new_data_d;
            trunc_q    <= trunc_d;
        end
    end

    sorter_read_mux #(
        .DEPTH (DEPTH),
        .IdxW  (CntW)
    ) u_read_mux (
        .cell_data (arr_cell_data),
        .idx       (idx_q),
        .data      (out_data)
    );

    // Everything below decodes registered state only; out_ready never reaches the outputs.
    assign out_valid    = (state_q == DRAIN);
    assign out_last     = (state_q == DRAIN) && (idx_q == idx_final);
    assign arr_clear    = (state_q == CLEAR);
    assign arr_new_data = new_data_q;
    assign frame_trunc  = trunc_q;
    assign busy         = !((state_q == LOAD) && (count_q == '0));

endmodule
